key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_pkg.sv | 19 +
 rtl/key_chan.sv | 122 ++++++++++++
 rtl/key_conditioner.sv | 58 +++++
 tb/tb_key_conditioner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the key conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_e;

  // Width able to hold every terminal count (largest parameter minus one).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchronizer, debounce filter and press/long/repeat FSM.
module key_chan
  import key_pkg::*;
#(
  parameter int DEB_CYCLES    = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       key_raw,
  output logic       level,
  output logic       press,
  output logic       rel,
  output logic       long_p,
  output logic       rpt,
  output key_state_e state
);

  localparam int            CW       = cnt_width(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic          IDLE_PIN = ACTIVE_LOW;
  localparam logic [CW-1:0] DEB_TC   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_TC  = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_TC   = CW'(REPEAT_CYCLES - 1);

  logic          sync1, sync2;
  logic          pressed_s;
  logic          level_d;
  logic          rise, fall;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] timer;

  assign pressed_s = sync2 ^ IDLE_PIN;
  assign rise      = level & ~level_d;
  assign fall      = ~level & level_d;

  // Level only flips after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1   <= IDLE_PIN;
      sync2   <= IDLE_PIN;
      level   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (pressed_s == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_TC) begin
        level   <= ~level;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end
    end
  end

  // Edge-triggered on level so a key already down when en rises stays silent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      timer   <= '0;
      level_d <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      long_p  <= 1'b0;
      rpt     <= 1'b0;
    end else begin
      level_d <= level;
      press   <= 1'b0;
      rel     <= 1'b0;
      long_p  <= 1'b0;
      rpt     <= 1'b0;
      if (!en) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= PRESSED;
              press <= 1'b1;
              timer <= '0;
            end
          end
          PRESSED: begin
            if (fall) begin
              state <= IDLE;
              rel   <= 1'b1;
              timer <= '0;
            end else if (timer == LONG_TC) begin
              state  <= HELD;
              long_p <= 1'b1;
              timer  <= '0;
            end else begin
              timer <= timer + CW'(1);
            end
          end
          HELD: begin
            if (fall) begin
              state <= IDLE;
              rel   <= 1'b1;
              timer <= '0;
            end else if (timer == REP_TC) begin
              rpt   <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel key conditioner: per-key debounce and event FSMs plus a press-code encoder.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NKEYS         = 4,
  parameter int DEB_CYCLES    = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [NKEYS-1:0]   key_i,
  output logic [NKEYS-1:0]   level_o,
  output logic [NKEYS-1:0]   press_o,
  output logic [NKEYS-1:0]   release_o,
  output logic [NKEYS-1:0]   long_o,
  output logic [NKEYS-1:0]   repeat_o,
  output logic [3:0]         code_o,
  output logic               code_valid_o,
  output logic [2*NKEYS-1:0] dbg_state
);

  key_state_e chan_state [NKEYS];

  for (genvar g = 0; g < NKEYS; g++) begin : g_chan
    key_chan #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .en     (en),
      .key_raw(key_i[g]),
      .level  (level_o[g]),
      .press  (press_o[g]),
      .rel    (release_o[g]),
      .long_p (long_o[g]),
      .rpt    (repeat_o[g]),
      .state  (chan_state[g])
    );
    assign dbg_state[2*g +: 2] = chan_state[g];
  end

  // Scan from the top down so the lowest pressed index wins.
  always_comb begin
    code_o = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (press_o[i]) code_o = 4'(i);
    end
  end

  assign code_valid_o = |press_o;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key/en traffic against a timestamp-based model.
module tb_key_conditioner;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b1;
  logic [NK-1:0] key_i = '1;
  logic [NK-1:0] level_o, press_o, release_o, long_o, repeat_o;
  logic [3:0]    code_o;
  logic          code_valid_o;
  logic [2*NK-1:0] dbg_state;

  key_conditioner #(
    .NKEYS(NK), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .key_i(key_i),
    .level_o(level_o), .press_o(press_o), .release_o(release_o), .long_o(long_o),
    .repeat_o(repeat_o), .code_o(code_o), .code_valid_o(code_valid_o), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;

  // Reference model: sample history per key, toggle timestamps, event timestamps.
  logic [15:0]   sh [NK];
  logic [NK-1:0] m_lvl, m_lvl_p;
  logic [NK-1:0] m_press, m_rel, m_long, m_rpt;
  logic [NK-1:0] active, held;
  int            last_tog [NK];
  int            t0 [NK];
  int            t1 [NK];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NK; ch++) begin
      sh[ch]       = '0;
      last_tog[ch] = n;
      t0[ch]       = 0;
      t1[ch]       = 0;
    end
    m_lvl = '0; m_lvl_p = '0;
    m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
    active = '0; held = '0;
  endtask

  task automatic model_edge();
    logic [NK-1:0] p1, p2, nl;
    logic agree;
    n++;
    if (!rstn) begin
      model_reset();
    end else begin
      p1 = m_lvl;
      p2 = m_lvl_p;
      nl = m_lvl;
      m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
      for (int ch = 0; ch < NK; ch++) begin
        sh[ch] = {sh[ch][14:0], ~key_i[ch]};
        agree = 1'b1;
        for (int k = 2; k <= DEB + 1; k++)
          if (sh[ch][k] == m_lvl[ch]) agree = 1'b0;
        if (agree && (n - last_tog[ch] >= DEB)) begin
          nl[ch] = ~m_lvl[ch];
          last_tog[ch] = n;
        end
        if (!en) begin
          active[ch] = 1'b0;
          held[ch]   = 1'b0;
        end else if (!active[ch]) begin
          if (p1[ch] && !p2[ch]) begin
            m_press[ch] = 1'b1; active[ch] = 1'b1; held[ch] = 1'b0; t0[ch] = n;
          end
        end else if (!p1[ch] && p2[ch]) begin
          m_rel[ch] = 1'b1; active[ch] = 1'b0; held[ch] = 1'b0;
        end else if (!held[ch] && (n - t0[ch] == LONG)) begin
          m_long[ch] = 1'b1; held[ch] = 1'b1; t1[ch] = n;
        end else if (held[ch] && ((n - t1[ch]) % REP == 0)) begin
          m_rpt[ch] = 1'b1;
        end
      end
      m_lvl_p = m_lvl;
      m_lvl   = nl;
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_code;
    exp_code = '0;
    for (int i = NK - 1; i >= 0; i--) if (m_press[i]) exp_code = 4'(i);
    chk("level_o",      32'(level_o),      32'(m_lvl));
    chk("press_o",      32'(press_o),      32'(m_press));
    chk("release_o",    32'(release_o),    32'(m_rel));
    chk("long_o",       32'(long_o),       32'(m_long));
    chk("repeat_o",     32'(repeat_o),     32'(m_rpt));
    chk("code_o",       32'(code_o),       32'(exp_code));
    chk("code_valid_o", 32'(code_valid_o), 32'(|m_press));
  endtask

  task automatic step(input logic [NK-1:0] k, input logic e);
    key_i = k;
    en    = e;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int fp, fl, lg, r1, r2, rl, pulses;
  logic [NK-1:0] kreg;
  logic          ereg;

  initial begin
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step('1, 1'b1);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) step('1, 1'b1);

    // Single press: level at edge 6, press at edge 7.
    fp = -1; fl = -1;
    for (int i = 1; i <= 10; i++) begin
      step(4'b1110, 1'b1);
      if (press_o[0] && fp < 0) fp = i;
      if (level_o[0] && fl < 0) fl = i;
    end
    chk("press_latency", 32'(fp), 32'd7);
    chk("level_latency", 32'(fl), 32'd6);
    for (int i = 0; i < 10; i++) step('1, 1'b1);

    // Short glitch is swallowed.
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(4'b1101, 1'b1);
      pulses += int'(|{press_o[1], release_o[1], level_o[1]});
    end
    for (int i = 0; i < 12; i++) begin
      step('1, 1'b1);
      pulses += int'(|{press_o[1], release_o[1], level_o[1]});
    end
    chk("glitch_quiet", 32'(pulses), 32'd0);

    // Long hold: long at +20, repeats at +8 and +16, release 7 edges after key up.
    fp = -1; lg = -1; r1 = -1; r2 = -1; rl = -1;
    for (int i = 1; i <= 60; i++) begin
      step(4'b1011, 1'b1);
      if (press_o[2] && fp < 0) fp = i;
      if (long_o[2] && lg < 0) lg = i;
      if (repeat_o[2] && r1 >= 0 && r2 < 0) r2 = i;
      if (repeat_o[2] && r1 < 0) r1 = i;
    end
    for (int i = 1; i <= 10; i++) begin
      step('1, 1'b1);
      if (release_o[2] && rl < 0) rl = i;
    end
    chk("long_delay", 32'(lg - fp), 32'd20);
    chk("repeat1_delay", 32'(r1 - lg), 32'd8);
    chk("repeat2_delay", 32'(r2 - lg), 32'd16);
    chk("release_latency", 32'(rl), 32'd7);

    // Simultaneous presses on keys 3 and 1.
    fp = -1;
    for (int i = 1; i <= 10; i++) begin
      step(4'b0101, 1'b1);
      if (code_valid_o && fp < 0) begin
        fp = i;
        chk("multi_press", 32'(press_o), 32'b1010);
        chk("multi_code", 32'(code_o), 32'd1);
      end
    end
    chk("multi_edge", 32'(fp), 32'd7);
    for (int i = 0; i < 10; i++) step('1, 1'b1);

    // en dropped while held, restored while still held: silent until re-press.
    for (int i = 0; i < 12; i++) step(4'b1110, 1'b1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(4'b1110, 1'b0);
      pulses += int'(|{press_o, release_o, long_o, repeat_o});
    end
    for (int i = 0; i < 30; i++) begin
      step(4'b1110, 1'b1);
      pulses += int'(press_o[0]);
    end
    chk("en_silent", 32'(pulses), 32'd0);
    for (int i = 0; i < 10; i++) step('1, 1'b1);
    fp = -1;
    for (int i = 1; i <= 10; i++) begin
      step(4'b1110, 1'b1);
      if (press_o[0] && fp < 0) fp = i;
    end
    chk("en_repress", 32'(fp), 32'd7);
    for (int i = 0; i < 10; i++) step('1, 1'b1);

    // Reset during HELD, key still down afterwards.
    for (int i = 0; i < 30; i++) step(4'b1011, 1'b1);
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < 2; i++) step(4'b1011, 1'b1);
    rstn = 1'b1;
    fp = -1;
    for (int i = 1; i <= 10; i++) begin
      step(4'b1011, 1'b1);
      if (press_o[2] && fp < 0) fp = i;
    end
    chk("reset_repress", 32'(fp), 32'd7);
    for (int i = 0; i < 10; i++) step('1, 1'b1);

    // Random traffic: key 0 glitchy, others slow enough to reach long/repeat.
    kreg = '1;
    ereg = 1'b1;
    for (int s = 0; s < 1500; s++) begin
      for (int ch = 0; ch < NK; ch++) begin
        if ($urandom_range(0, 99) < ((ch == 0) ? 20 : 2)) kreg[ch] = ~kreg[ch];
      end
      if ($urandom_range(0, 199) == 0) ereg = ~ereg;
      if (!ereg && $urandom_range(0, 19) == 0) ereg = 1'b1;
      if (s == 700) begin
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        step(kreg, ereg);
        rstn = 1'b1;
      end
      step(kreg, ereg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
